// File: rtl/acorn128_pkg.sv
// Shared encodings and default step counts for the ACORN-128 step sequencer.
package acorn128_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_INIT   = 3'd1,
    PH_AD     = 3'd2,
    PH_ADPAD  = 3'd3,
    PH_MSG    = 3'd4,
    PH_MSGPAD = 3'd5,
    PH_FINAL  = 3'd6,
    PH_DONE   = 3'd7
  } phase_e;

  // m-bit source select seen by the datapath
  localparam logic [2:0] MSEL_ZERO    = 3'd0;
  localparam logic [2:0] MSEL_ONE     = 3'd1;
  localparam logic [2:0] MSEL_KEY     = 3'd2;
  localparam logic [2:0] MSEL_KEY_INV = 3'd3;
  localparam logic [2:0] MSEL_IV      = 3'd4;
  localparam logic [2:0] MSEL_DATA    = 3'd5;

  localparam int INIT_STEPS_DEF  = 1792;
  localparam int PAD_STEPS_DEF   = 256;
  localparam int FINAL_STEPS_DEF = 768;

  // key and IV are each 128 bits; the tag is the last 128 keystream bits
  localparam int KEY_BITS = 128;
  localparam int TAG_BITS = 128;

endpackage

// File: rtl/acorn128_step_decode.sv
// Combinational decode of phase + step counter into datapath control bits.
module acorn128_step_decode
  import acorn128_pkg::*;
#(
  parameter int CNT_W       = 64,
  parameter int FINAL_STEPS = FINAL_STEPS_DEF
) (
  input  logic [2:0]       phase_in,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [2:0]       msel_out,
  output logic [6:0]       key_idx_out,
  output logic [6:0]       iv_idx_out,
  output logic             ca_out,
  output logic             cb_out,
  output logic             tag_en_out,
  output logic [6:0]       tag_idx_out
);

  localparam logic [CNT_W-1:0] KEY_END  = CNT_W'(KEY_BITS);
  localparam logic [CNT_W-1:0] IV_END   = CNT_W'(2 * KEY_BITS);
  localparam logic [CNT_W-1:0] TAG_BASE = CNT_W'(FINAL_STEPS - TAG_BITS);

  logic cnt_zero;
  logic cnt_low;

  assign cnt_zero = (cnt_in == '0);
  assign cnt_low  = (cnt_in < KEY_END);

  // per-phase control decode; everything defaults to 0 outside its phase
  always_comb begin
    msel_out    = MSEL_ZERO;
    key_idx_out = '0;
    iv_idx_out  = '0;
    ca_out      = 1'b0;
    cb_out      = 1'b0;
    tag_en_out  = 1'b0;
    tag_idx_out = '0;
    case (phase_in)
      PH_INIT: begin
        ca_out = 1'b1;
        cb_out = 1'b1;
        if (cnt_low) begin
          msel_out    = MSEL_KEY;
          key_idx_out = cnt_in[6:0];
        end else if (cnt_in < IV_END) begin
          msel_out   = MSEL_IV;
          iv_idx_out = cnt_in[6:0];
        end else if (cnt_in == IV_END) begin
          // key bit 0 inverted marks the end of key/IV loading
          msel_out = MSEL_KEY_INV;
        end else begin
          msel_out    = MSEL_KEY;
          key_idx_out = cnt_in[6:0];
        end
      end
      PH_AD: begin
        msel_out = MSEL_DATA;
        ca_out   = 1'b1;
        cb_out   = 1'b1;
      end
      PH_ADPAD: begin
        cb_out   = 1'b1;
        ca_out   = cnt_low;
        msel_out = cnt_zero ? MSEL_ONE : MSEL_ZERO;
      end
      PH_MSG: begin
        msel_out = MSEL_DATA;
        ca_out   = 1'b1;
      end
      PH_MSGPAD: begin
        ca_out   = cnt_low;
        msel_out = cnt_zero ? MSEL_ONE : MSEL_ZERO;
      end
      PH_FINAL: begin
        ca_out = 1'b1;
        cb_out = 1'b1;
        if (cnt_in >= TAG_BASE) begin
          tag_en_out  = 1'b1;
          // offset from TAG_BASE is < 128, so the low 7 bits suffice
          tag_idx_out = cnt_in[6:0] - TAG_BASE[6:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acorn128_step_sequencer.sv
// Phase FSM and step counter driving the bit-serial ACORN-128 datapath.
module acorn128_step_sequencer
  import acorn128_pkg::*;
#(
  parameter int INIT_STEPS  = INIT_STEPS_DEF,
  parameter int PAD_STEPS   = PAD_STEPS_DEF,
  parameter int FINAL_STEPS = FINAL_STEPS_DEF,
  parameter int LEN_W       = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             encrypt_in,
  input  logic [LEN_W-1:0] ad_len_in,
  input  logic [LEN_W-1:0] msg_len_in,
  input  logic             data_valid_in,
  output logic             data_req_out,
  output logic             step_en_out,
  output logic [2:0]       phase_out,
  output logic [2:0]       msel_out,
  output logic [6:0]       key_idx_out,
  output logic [6:0]       iv_idx_out,
  output logic             ca_out,
  output logic             cb_out,
  output logic             decrypt_out,
  output logic             cipher_en_out,
  output logic             tag_en_out,
  output logic [6:0]       tag_idx_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam logic [LEN_W-1:0] INIT_LAST  = LEN_W'(INIT_STEPS - 1);
  localparam logic [LEN_W-1:0] PAD_LAST   = LEN_W'(PAD_STEPS - 1);
  localparam logic [LEN_W-1:0] FINAL_LAST = LEN_W'(FINAL_STEPS - 1);
  localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);

  phase_e           phase_q, phase_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] ad_len_q, ad_len_d;
  logic [LEN_W-1:0] msg_len_q, msg_len_d;
  logic             decrypt_q, decrypt_d;

  // state register: phase, step counter and operands latched at start
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH_IDLE;
      cnt_q     <= '0;
      ad_len_q  <= '0;
      msg_len_q <= '0;
      decrypt_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      ad_len_q  <= ad_len_d;
      msg_len_q <= msg_len_d;
      decrypt_q <= decrypt_d;
    end
  end

  // next-state, counter and handshake/strobe outputs; cnt clears on every phase entry
  always_comb begin
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    ad_len_d      = ad_len_q;
    msg_len_d     = msg_len_q;
    decrypt_d     = decrypt_q;
    step_en_out   = 1'b0;
    data_req_out  = 1'b0;
    cipher_en_out = 1'b0;
    done_out      = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        if (start_in) begin
          phase_d   = PH_INIT;
          cnt_d     = '0;
          ad_len_d  = ad_len_in;
          msg_len_d = msg_len_in;
          decrypt_d = ~encrypt_in;
        end
      end
      PH_INIT: begin
        step_en_out = 1'b1;
        if (cnt_q == INIT_LAST) begin
          cnt_d = '0;
          if (ad_len_q == '0) phase_d = PH_ADPAD;
          else                phase_d = PH_AD;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PH_AD: begin
        data_req_out = 1'b1;
        step_en_out  = data_valid_in;
        if (data_valid_in) begin
          if (cnt_q == ad_len_q - ONE) begin
            phase_d = PH_ADPAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      PH_ADPAD: begin
        step_en_out = 1'b1;
        if (cnt_q == PAD_LAST) begin
          cnt_d = '0;
          if (msg_len_q == '0) phase_d = PH_MSGPAD;
          else                 phase_d = PH_MSG;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PH_MSG: begin
        data_req_out  = 1'b1;
        step_en_out   = data_valid_in;
        cipher_en_out = data_valid_in;
        if (data_valid_in) begin
          if (cnt_q == msg_len_q - ONE) begin
            phase_d = PH_MSGPAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      PH_MSGPAD: begin
        step_en_out = 1'b1;
        if (cnt_q == PAD_LAST) begin
          phase_d = PH_FINAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PH_FINAL: begin
        step_en_out = 1'b1;
        if (cnt_q == FINAL_LAST) begin
          phase_d = PH_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PH_DONE: begin
        done_out = 1'b1;
        phase_d  = PH_IDLE;
        cnt_d    = '0;
      end
      default: begin
        phase_d = PH_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign phase_out   = phase_q;
  assign busy_out    = (phase_q != PH_IDLE);
  assign decrypt_out = decrypt_q;

  acorn128_step_decode #(
    .CNT_W       (LEN_W),
    .FINAL_STEPS (FINAL_STEPS)
  ) u_decode (
    .phase_in    (phase_q),
    .cnt_in      (cnt_q),
    .msel_out    (msel_out),
    .key_idx_out (key_idx_out),
    .iv_idx_out  (iv_idx_out),
    .ca_out      (ca_out),
    .cb_out      (cb_out),
    .tag_en_out  (tag_en_out),
    .tag_idx_out (tag_idx_out)
  );

endmodule

// File: tb/tb_acorn128_step_sequencer.sv
// Directed bench for the ACORN-128 step sequencer.
module tb_acorn128_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic        encrypt_in;
  logic [63:0] ad_len_in;
  logic [63:0] msg_len_in;
  logic        data_valid_in;
  logic        data_req_out;
  logic        step_en_out;
  logic [2:0]  phase_out;
  logic [2:0]  msel_out;
  logic [6:0]  key_idx_out;
  logic [6:0]  iv_idx_out;
  logic        ca_out;
  logic        cb_out;
  logic        decrypt_out;
  logic        cipher_en_out;
  logic        tag_en_out;
  logic [6:0]  tag_idx_out;
  logic        busy_out;
  logic        done_out;

  int checks = 0;
  int errors = 0;

  // per-operation observations
  int r_steps, r_first, r_last, r_ad, r_msg, r_cipher;
  int r_done_cnt, r_done_cyc, r_busy_after, r_phase_after;
  int r_stall_bad, r_req_bad, r_init_bad;
  int r_tag, r_tag_first, r_tag_first_idx, r_tag_last, r_tag_last_idx;

  always #5 clk = ~clk;

  acorn128_step_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start_in      (start_in),
    .encrypt_in    (encrypt_in),
    .ad_len_in     (ad_len_in),
    .msg_len_in    (msg_len_in),
    .data_valid_in (data_valid_in),
    .data_req_out  (data_req_out),
    .step_en_out   (step_en_out),
    .phase_out     (phase_out),
    .msel_out      (msel_out),
    .key_idx_out   (key_idx_out),
    .iv_idx_out    (iv_idx_out),
    .ca_out        (ca_out),
    .cb_out        (cb_out),
    .decrypt_out   (decrypt_out),
    .cipher_en_out (cipher_en_out),
    .tag_en_out    (tag_en_out),
    .tag_idx_out   (tag_idx_out),
    .busy_out      (busy_out),
    .done_out      (done_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] dvec();
    return {msel_out, key_idx_out, iv_idx_out, ca_out, cb_out, tag_en_out, tag_idx_out};
  endfunction

  function automatic logic [26:0] ev(input logic [2:0] m, input logic [6:0] k, input logic [6:0] v,
                                     input logic a, input logic b, input logic t, input logic [6:0] ti);
    return {m, k, v, a, b, t, ti};
  endfunction

  function automatic logic [37:0] allvec();
    return {step_en_out, data_req_out, phase_out, dvec(), decrypt_out, cipher_en_out, busy_out, done_out};
  endfunction

  // One full operation: start in cycle 0, sample each cycle at negedge until done,
  // then one more IDLE cycle (optionally carrying a new start) and one after that.
  task automatic run_op(input logic [63:0] ad, input logic [63:0] msg, input bit tog,
                        input int busy_start_cyc, input bit restart);
    int pc;
    logic [2:0] pph;
    r_steps = 0; r_first = -1; r_last = -1; r_ad = 0; r_msg = 0; r_cipher = 0;
    r_done_cnt = 0; r_done_cyc = -1; r_busy_after = -1; r_phase_after = -1;
    r_stall_bad = 0; r_req_bad = 0; r_init_bad = 0;
    r_tag = 0; r_tag_first = -1; r_tag_first_idx = -1; r_tag_last = -1; r_tag_last_idx = -1;
    @(posedge clk); #1;
    start_in = 1'b1; encrypt_in = 1'b1; ad_len_in = ad; msg_len_in = msg; data_valid_in = 1'b1;
    @(negedge clk);
    pph = 3'd0; pc = 0;
    for (int c = 1; c < 6000; c++) begin
      @(posedge clk); #1;
      start_in      = (c == busy_start_cyc);
      ad_len_in     = 64'hFFFF;
      msg_len_in    = 64'hFFFF;
      data_valid_in = tog ? c[0] : 1'b1;
      @(negedge clk);
      if (phase_out !== pph) pc = 0;
      pph = phase_out;
      if (step_en_out) begin
        r_steps++;
        if (r_first < 0) r_first = c;
        r_last = c;
      end
      if (phase_out == 3'd2 && step_en_out) r_ad++;
      if (phase_out == 3'd4 && step_en_out) r_msg++;
      if (cipher_en_out) r_cipher++;
      if ((phase_out == 3'd2 || phase_out == 3'd4) && step_en_out !== data_valid_in) r_stall_bad++;
      if (cipher_en_out !== (phase_out == 3'd4 && data_valid_in)) r_stall_bad++;
      if (data_req_out !== (phase_out == 3'd2 || phase_out == 3'd4)) r_req_bad++;
      if (phase_out == 3'd1 && (ca_out !== 1'b1 || cb_out !== 1'b1)) r_init_bad++;
      if (tag_en_out) begin
        r_tag++;
        if (r_tag_first < 0) begin r_tag_first = pc; r_tag_first_idx = int'(tag_idx_out); end
        r_tag_last = pc; r_tag_last_idx = int'(tag_idx_out);
      end
      if (phase_out == 3'd1 && pc == 0)   chk("init_c0",   64'(dvec()), 64'(ev(3'd2, 7'd0,   7'd0, 1, 1, 0, 7'd0)));
      if (phase_out == 3'd1 && pc == 128) chk("init_c128", 64'(dvec()), 64'(ev(3'd4, 7'd0,   7'd0, 1, 1, 0, 7'd0)));
      if (phase_out == 3'd1 && pc == 256) chk("init_c256", 64'(dvec()), 64'(ev(3'd3, 7'd0,   7'd0, 1, 1, 0, 7'd0)));
      if (phase_out == 3'd1 && pc == 383) chk("init_c383", 64'(dvec()), 64'(ev(3'd2, 7'd127, 7'd0, 1, 1, 0, 7'd0)));
      if (phase_out == 3'd3 && pc == 0)   chk("adpad_c0",  64'(dvec()), 64'(ev(3'd1, 7'd0,   7'd0, 1, 1, 0, 7'd0)));
      if (phase_out == 3'd3 && pc == 128) chk("adpad_c128",64'(dvec()), 64'(ev(3'd0, 7'd0,   7'd0, 0, 1, 0, 7'd0)));
      if (phase_out == 3'd5 && pc == 127) chk("msgpad_c127",64'(dvec()),64'(ev(3'd0, 7'd0,   7'd0, 1, 0, 0, 7'd0)));
      if (phase_out == 3'd4 && pc == 0 && step_en_out)
        chk("msg_decode", 64'(dvec()), 64'(ev(3'd5, 7'd0, 7'd0, 1, 0, 0, 7'd0)));
      if (step_en_out) pc++;
      if (done_out) begin
        r_done_cnt++;
        r_done_cyc = c;
        break;
      end
    end
    @(posedge clk); #1;
    start_in = restart; data_valid_in = 1'b1;
    @(negedge clk);
    r_busy_after = int'(busy_out);
    if (done_out) r_done_cnt++;
    @(posedge clk); #1;
    start_in = 1'b0;
    @(negedge clk);
    r_phase_after = int'(phase_out);
  endtask

  initial begin
    int dcount;
    bit reached;
    rst = 1'b1; start_in = 1'b0; encrypt_in = 1'b0; ad_len_in = '0; msg_len_in = '0; data_valid_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'(allvec()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", 64'(allvec()), 64'd0);

    // empty AD and message, feeder always valid
    run_op(64'd0, 64'd0, 1'b0, -1, 1'b0);
    chk("t1_steps",      64'(r_steps), 64'd3072);
    chk("t1_first_step", 64'(r_first), 64'd1);
    chk("t1_last_step",  64'(r_last),  64'd3072);
    chk("t1_done_cyc",   64'(r_done_cyc), 64'd3073);
    chk("t1_done_cnt",   64'(r_done_cnt), 64'd1);
    chk("t1_busy_after", 64'(r_busy_after), 64'd0);
    chk("t1_init_cacb",  64'(r_init_bad), 64'd0);
    chk("t1_ad_msg",     64'({32'(r_ad), 32'(r_msg)}), 64'd0);
    chk("t1_tag_cnt",    64'(r_tag), 64'd128);
    chk("t1_tag_first",  64'({32'(r_tag_first), 32'(r_tag_first_idx)}), {32'd640, 32'd0});
    chk("t1_tag_last",   64'({32'(r_tag_last),  32'(r_tag_last_idx)}),  {32'd767, 32'd127});
    chk("t1_req",        64'(r_req_bad), 64'd0);

    // 5 AD bits, 3 message bits, feeder valid every other cycle
    run_op(64'd5, 64'd3, 1'b1, -1, 1'b0);
    chk("t3_ad_steps",   64'(r_ad), 64'd5);
    chk("t3_msg_steps",  64'(r_msg), 64'd3);
    chk("t3_cipher",     64'(r_cipher), 64'd3);
    chk("t3_total",      64'(r_steps), 64'd3080);
    chk("t3_stall",      64'(r_stall_bad), 64'd0);
    chk("t3_req",        64'(r_req_bad), 64'd0);
    chk("t3_done_cnt",   64'(r_done_cnt), 64'd1);
    chk("t3_tag_cnt",    64'(r_tag), 64'd128);

    // start pulsed mid-INIT is ignored; start right after DONE is accepted
    run_op(64'd0, 64'd0, 1'b0, 500, 1'b1);
    chk("t5_steps",      64'(r_steps), 64'd3072);
    chk("t5_done_cyc",   64'(r_done_cyc), 64'd3073);
    chk("t5_restart",    64'(r_phase_after), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_reset_idle", 64'(allvec()), 64'd0);

    // reset while in MSG
    @(posedge clk); #1;
    start_in = 1'b1; encrypt_in = 1'b0; ad_len_in = 64'd0; msg_len_in = 64'd10; data_valid_in = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      start_in = 1'b0;
      @(negedge clk);
      if (phase_out == 3'd4) begin reached = 1'b1; break; end
    end
    chk("t4_reach_msg", 64'(reached), 64'd1);
    chk("t4_msg_state", 64'({data_req_out, decrypt_out, cipher_en_out}), 64'b111);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_after_rst", 64'(allvec()), 64'd0);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done_out || busy_out) dcount++;
    end
    chk("t4_no_done", 64'(dcount), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acorn128_step_sequencer.md
Name: acorn128_step_sequencer

Overview:
- Control sequencer for the bit-serial ACORN-128 state-update datapath.
- Per state-update step, it drives: step enable, message-bit source select, ca/cb control bits, key/IV bit indices, and ciphertext/tag strobes.
- Walks the datapath through init (1792), AD, AD padding (256), message, message padding (256) and finalization (768) steps.
- AD and message bits arrive from an external bit feeder over a valid/req handshake.

Parameters:
- INIT_STEPS, 1792, initialization steps
- PAD_STEPS, 256, padding steps after AD and after message
- FINAL_STEPS, 768, finalization steps
- LEN_W, 64, width of bit-length inputs

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_in  in  1  begin operation; sampled only in IDLE
- encrypt_in  in  1  1 = encrypt, 0 = decrypt; latched on start
- ad_len_in  in  LEN_W  associated-data length in bits; latched on start
- msg_len_in  in  LEN_W  message length in bits; latched on start
- data_valid_in  in  1  feeder presents a valid AD/message bit this cycle
- data_req_out  out  1  sequencer wants a data bit (phase AD or MSG)
- step_en_out  out  1  datapath performs one state update this cycle
- phase_out  out  3  IDLE=0, INIT=1, AD=2, ADPAD=3, MSG=4, MSGPAD=5, FINAL=6, DONE=7
- msel_out  out  3  m-bit source: 0 zero, 1 one, 2 key[key_idx], 3 key[key_idx]^1, 4 iv[iv_idx], 5 external data bit
- key_idx_out  out  7  key bit index
- iv_idx_out  out  7  IV bit index
- ca_out  out  1  ca control bit
- cb_out  out  1  cb control bit
- decrypt_out  out  1  latched ~encrypt_in
- cipher_en_out  out  1  keystream bit this step produces a ciphertext/plaintext bit
- tag_en_out  out  1  keystream bit this step is a tag bit
- tag_idx_out  out  7  tag bit index
- busy_out  out  1  phase not IDLE
- done_out  out  1  one-cycle pulse in DONE

Behaviour:
- Reset sync: phase IDLE, step counter 0, latched lengths 0, decrypt_out 0; all outputs 0.
- Outputs are Moore, decoded from phase and the 64-bit step counter cnt. cnt resets to 0 on every phase entry.
- IDLE: start_in=1 latches inputs, moves to INIT next cycle. start_in is ignored in every other phase.
- INIT: step_en=1, ca=1, cb=1.
  - cnt 0..127: msel=2, key_idx=cnt[6:0]
  - cnt 128..255: msel=4, iv_idx=cnt[6:0]
  - cnt 256: msel=3, key_idx=0
  - cnt 257..1791: msel=2, key_idx=cnt[6:0]
  - At cnt=INIT_STEPS-1: go to AD, or to ADPAD if ad_len=0.
- AD: data_req=1, msel=5, ca=1, cb=1, step_en=data_valid_in. cnt advances only on step_en. Last accepted bit (cnt=ad_len-1) moves to ADPAD.
- ADPAD: step_en=1, cb=1, ca=(cnt<128), msel=1 at cnt 0, else 0. At cnt=PAD_STEPS-1: go to MSG, or to MSGPAD if msg_len=0.
- MSG: data_req=1, msel=5, ca=1, cb=0, step_en=cipher_en=data_valid_in. Stalls like AD. Last bit moves to MSGPAD.
- MSGPAD: step_en=1, cb=0, ca=(cnt<128), msel=1 at cnt 0, else 0. Last step moves to FINAL.
- FINAL: step_en=1, ca=1, cb=1, msel=0.
  - tag_en=1 for cnt >= FINAL_STEPS-128; tag_idx=cnt-(FINAL_STEPS-128).
  - Last step moves to DONE.
- DONE: done_out=1 for one cycle, then IDLE. A start_in in the following IDLE cycle is accepted.
- Outputs outside their listed phase are 0, including indices.
- Stall: data_valid_in=0 in AD/MSG holds everything. data_valid_in outside AD/MSG is ignored.
- Length compare uses full LEN_W bits. No wrap; counter max is 2^64-1.
- Mid-operation rst: IDLE next cycle, no done_out.

Decomposition:
- Shared package acorn128_pkg holds:
  - phase encoding constants
  - msel encoding constants
  - INIT/PAD/FINAL step-count defaults
- Natural sub-module: acorn128_step_decode. It is combinational and maps phase+cnt to msel, key_idx, iv_idx, ca, cb, tag_en and tag_idx.
- The FSM and counter stay in the top.

Test Plan:
- ad_len=0, msg_len=0, data_valid_in=1, start pulse at cycle 0:
  - step_en high cycles 1..3072 contiguous (1792+256+256+768)
  - done_out only at cycle 3073
  - busy low at 3074
- Init decode check:
  - INIT cnt 0: msel=2, key_idx=0
  - cnt 128: msel=4, iv_idx=0
  - cnt 256: msel=3, key_idx=0
  - cnt 383: msel=2, key_idx=127
  - ca=cb=1 throughout
- ad_len=5, msg_len=3, data_valid toggling 1,0,1,0:
  - exactly 5 AD and 3 MSG step_en pulses, only where valid=1
  - 3 cipher_en pulses
  - total steps 3080
- Padding: ADPAD cnt 0 gives msel=1, ca=1, cb=1. ADPAD cnt 128 gives msel=0, ca=0, cb=1. MSGPAD cnt 127 gives ca=1, cb=0.
- FINAL: tag_en rises at cnt 640 with tag_idx=0, and is last high at cnt 767 with tag_idx=127. Exactly 128 tag_en pulses.
- Reset and start handling:
  - rst asserted in MSG phase → phase 0 next cycle, all outputs 0, no done_out
  - start_in pulsed while busy → ignored, step count unchanged
